// File: rtl/elink_pkg.sv
// rtl/elink_pkg.sv - shared constants, types and width helpers for the elink receive path
package elink_pkg;

   localparam int LANES_DEF = 9;
   localparam int RATIO_DEF = 4;

   typedef enum logic {
      TARGET_E16 = 1'b0,
      TARGET_E64 = 1'b1
   } elink_target_e;

   typedef enum logic {
      SLIP_IDLE    = 1'b0,
      SLIP_PENDING = 1'b1
   } slip_state_e;

   // Bits collected per lane per word: both DDR edges over RATIO fast cycles.
   function automatic int word_w(input int ratio);
      return 2 * ratio;
   endfunction

   // Width of the bit-offset register, able to hold 0 .. word_w-1.
   function automatic int offset_w(input int ratio);
      return (ratio < 1) ? 1 : $clog2(2 * ratio);
   endfunction

   // E64 boards route the receive pairs with swapped polarity.
   function automatic bit invert_default(input elink_target_e target);
      return target == TARGET_E64;
   endfunction

   localparam bit INVERT_E16 = 1'b0;
   localparam bit INVERT_E64 = 1'b1;
   localparam bit INVERT_DEF = INVERT_E16;

endpackage

// File: rtl/elink_rx_deser_if.sv
// rtl/elink_rx_deser_if.sv - pin-side pairs and word-side outputs of the receive deserializer
interface elink_rx_deser_if
   import elink_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int RATIO = RATIO_DEF
);
   localparam int WW = word_w(RATIO);
   localparam int OW = offset_w(RATIO);

   logic [LANES-1:0]    EVEN_IN;
   logic [LANES-1:0]    ODD_IN;
   logic                BITSLIP;
   logic                PHASE_SYNC;
   logic [LANES*WW-1:0] DATA_OUT;
   logic                DATA_VALID;
   logic                SLIP_BUSY;
   logic [OW-1:0]       OFFSET;

   modport master (
      output EVEN_IN, ODD_IN, BITSLIP, PHASE_SYNC,
      input  DATA_OUT, DATA_VALID, SLIP_BUSY, OFFSET
   );

   modport slave (
      input  EVEN_IN, ODD_IN, BITSLIP, PHASE_SYNC,
      output DATA_OUT, DATA_VALID, SLIP_BUSY, OFFSET
   );

endinterface

// File: rtl/elink_rx_lane_shift.sv
// rtl/elink_rx_lane_shift.sv - one lane: input register, bit history and offset window select
module elink_rx_lane_shift #(
   parameter int RATIO  = 4,
   parameter bit INVERT = 1'b0,
   parameter int OW     = 3
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              even_i,
   input  logic              odd_i,
   input  logic [OW-1:0]     offset_i,
   output logic [2*RATIO-1:0] window_o
);
   localparam int WW = 2 * RATIO;
   localparam int HW = 4 * RATIO;

   logic          even_q, even_d;
   logic          odd_q, odd_d;
   logic [HW-1:0] hist_q, hist_d;
   logic [HW-1:0] shifted;

   // Next-state: polarity-corrected pair in, history shifts by one pair (oldest at MSB).
   always_comb begin
      even_d = even_i ^ INVERT;
      odd_d  = odd_i ^ INVERT;
      hist_d = {hist_q[HW-3:0], even_q, odd_q};
   end

   // Pair register and history, cleared immediately on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         even_q <= 1'b0;
         odd_q  <= 1'b0;
         hist_q <= '0;
      end else begin
         even_q <= even_d;
         odd_q  <= odd_d;
         hist_q <= hist_d;
      end
   end

   // Word window starts OFFSET bits above the newest bit; the history is wide enough for any offset.
   always_comb begin
      shifted  = hist_q >> offset_i;
      window_o = shifted[WW-1:0];
   end

endmodule

// File: rtl/elink_rx_deser.sv
// rtl/elink_rx_deser.sv - fast-clock elink lane deserializer with bitslip and word-phase sync
module elink_rx_deser
   import elink_pkg::*;
#(
   parameter int LANES  = LANES_DEF,
   parameter int RATIO  = RATIO_DEF,
   parameter bit INVERT = INVERT_DEF
) (
   input  logic             CLK,
   input  logic             RESET_N,
   elink_rx_deser_if.slave  rx
);
   localparam int WW = word_w(RATIO);
   localparam int OW = offset_w(RATIO);
   localparam int PW = (RATIO > 1) ? $clog2(RATIO) : 1;

   localparam logic [PW-1:0] PHASE_LAST  = PW'(RATIO - 1);
   localparam logic [OW-1:0] OFFSET_LAST = OW'(WW - 1);

   logic [PW-1:0]       phase_q, phase_d;
   slip_state_e         slip_q, slip_d;
   logic [OW-1:0]       offset_q, offset_d;
   logic [LANES*WW-1:0] data_q, data_d;
   logic                valid_q, valid_d;
   logic [LANES*WW-1:0] window_all;
   logic                boundary;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      elink_rx_lane_shift #(
         .RATIO  (RATIO),
         .INVERT (INVERT),
         .OW     (OW)
      ) u_lane (
         .clk_i    (CLK),
         .rst_ni   (RESET_N),
         .even_i   (rx.EVEN_IN[g]),
         .odd_i    (rx.ODD_IN[g]),
         .offset_i (offset_q),
         .window_o (window_all[g*WW +: WW])
      );
   end

   // Word phase: a sync pulse restarts the count and suppresses the boundary it lands on.
   always_comb begin
      boundary = (phase_q == PHASE_LAST) && !rx.PHASE_SYNC;
      phase_d  = phase_q + PW'(1);
      if (rx.PHASE_SYNC || (phase_q == PHASE_LAST)) begin
         phase_d = '0;
      end
   end

   // Slip control: one pending request at a time, applied after the next word is captured.
   always_comb begin
      slip_d   = slip_q;
      offset_d = offset_q;
      case (slip_q)
         SLIP_IDLE: begin
            if (rx.BITSLIP) begin
               slip_d = SLIP_PENDING;
            end
         end
         SLIP_PENDING: begin
            if (boundary) begin
               slip_d   = SLIP_IDLE;
               offset_d = (offset_q == OFFSET_LAST) ? '0 : offset_q + OW'(1);
            end
         end
         default: slip_d = SLIP_IDLE;
      endcase
   end

   // Output word is captured with the offset in force before any slip lands on this boundary.
   always_comb begin
      data_d  = data_q;
      valid_d = boundary;
      if (boundary) begin
         data_d = window_all;
      end
   end

   // Control and output registers, cleared immediately on reset.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         phase_q  <= '0;
         slip_q   <= SLIP_IDLE;
         offset_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         slip_q   <= slip_d;
         offset_q <= offset_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
      end
   end

   assign rx.DATA_OUT   = data_q;
   assign rx.DATA_VALID = valid_q;
   assign rx.SLIP_BUSY  = (slip_q == SLIP_PENDING);
   assign rx.OFFSET     = offset_q;

endmodule
